// File: rtl/parking_meter_timer.sv
// Parking-meter countdown core: accumulates button credits, counts down once per
// second, and presents the remaining time as BCD with a blink/blank control.
module parking_meter_timer #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned INC_U       = 10,
    parameter int unsigned INC_L       = 180,
    parameter int unsigned INC_R       = 200,
    parameter int unsigned INC_D       = 550
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pulse_btnu,
    input  logic        pulse_btnl,
    input  logic        pulse_btnr,
    input  logic        pulse_btnd,
    input  logic        sw0,
    input  logic        sw1,
    output logic [15:0] bcd,
    output logic        blank,
    output logic        zero
);

    localparam int unsigned PW        = $clog2(TICK_CYCLES);
    localparam logic [13:0] MAX_COUNT = 14'd9999;

    logic [13:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          phase_q, phase_d;

    logic          tick;
    logic          dec;
    logic [14:0]   inc;
    logic [14:0]   sum;
    logic [13:0]   sat;

    always_comb begin
        tick = (presc_q == PW'(TICK_CYCLES - 1));
        dec  = tick && (count_q != '0);
        inc  = (pulse_btnu ? 15'(INC_U) : '0)
             + (pulse_btnl ? 15'(INC_L) : '0)
             + (pulse_btnr ? 15'(INC_R) : '0)
             + (pulse_btnd ? 15'(INC_D) : '0);
        // 15-bit sum so the saturation compare sees the true overflow
        sum  = {1'b0, count_q} + inc;
        sat  = (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[13:0];

        count_d = count_q;
        presc_d = presc_q;
        phase_d = phase_q;
        if (sw1) begin
            count_d = 14'd185;
            presc_d = '0;
            phase_d = 1'b0;
        end else if (sw0) begin
            count_d = 14'd15;
            presc_d = '0;
            phase_d = 1'b0;
        end else begin
            count_d = sat - {13'b0, dec};
            presc_d = tick ? '0 : presc_q + PW'(1);
            phase_d = phase_q ^ tick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            presc_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    // Shift-and-add-3 conversion; count never exceeds 9999 so four digits suffice
    always_comb begin
        logic [29:0] dd;
        dd = {16'b0, count_q};
        for (int unsigned i = 0; i < 14; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (dd[14 + 4*j +: 4] >= 4'd5) begin
                    dd[14 + 4*j +: 4] = dd[14 + 4*j +: 4] + 4'd3;
                end
            end
            dd = dd << 1;
        end
        bcd = dd[29:14];
    end

    always_comb begin
        zero  = (count_q == '0);
        blank = 1'b0;
        if (count_q == '0) begin
            blank = (presc_q >= PW'(TICK_CYCLES / 2));
        end else if (count_q <= 14'd199) begin
            blank = phase_q;
        end
    end

endmodule

// File: tb/tb_parking_meter_timer.sv
// Scoreboard bench for parking_meter_timer: directed scenarios plus random traffic,
// expectations from an arithmetic reference model of the meter's rules.
module tb_parking_meter_timer;

    localparam int T = 10;

    typedef struct {
        logic [15:0] bcd;
        logic        zero;
        logic        blank;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pulse_btnu = 1'b0, pulse_btnl = 1'b0, pulse_btnr = 1'b0, pulse_btnd = 1'b0;
    logic        sw0 = 1'b0, sw1 = 1'b0;
    logic [15:0] bcd;
    logic        blank, zero;

    int   checks = 0;
    int   errors = 0;
    bit   running = 1'b1;
    exp_t sb_q[$];

    // Reference model: remaining seconds and cycles since the prescaler last restarted
    int m_count = 0;
    int m_since = 0;

    parking_meter_timer #(
        .TICK_CYCLES(T),
        .INC_U(10),
        .INC_L(180),
        .INC_R(200),
        .INC_D(550)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pulse_btnu(pulse_btnu),
        .pulse_btnl(pulse_btnl),
        .pulse_btnr(pulse_btnr),
        .pulse_btnd(pulse_btnd),
        .sw0(sw0),
        .sw1(sw1),
        .bcd(bcd),
        .blank(blank),
        .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_outputs();
        exp_t e;
        int   presc;
        int   phase;
        presc   = m_since % T;
        phase   = (m_since / T) % 2;
        e.bcd   = {4'(m_count / 1000), 4'((m_count / 100) % 10),
                   4'((m_count / 10) % 10), 4'(m_count % 10)};
        e.zero  = (m_count == 0);
        if (m_count == 0)        e.blank = (presc >= T / 2);
        else if (m_count <= 199) e.blank = (phase == 1);
        else                     e.blank = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, required, $time);
        end
    endtask

    // Drive one cycle, advance the model across the coming edge, queue the expectation
    task automatic step(input bit r, input bit s0, input bit s1,
                        input bit u, input bit l, input bit rr, input bit d);
        int sum;
        bit tick;
        rst = r; sw0 = s0; sw1 = s1;
        pulse_btnu = u; pulse_btnl = l; pulse_btnr = rr; pulse_btnd = d;
        if (r) begin
            m_count = 0;   m_since = 0;
        end else if (s1) begin
            m_count = 185; m_since = 0;
        end else if (s0) begin
            m_count = 15;  m_since = 0;
        end else begin
            tick = (m_since % T == T - 1);
            sum  = m_count + 10 * int'(u) + 180 * int'(l) + 200 * int'(rr) + 550 * int'(d);
            if (sum > 9999) sum = 9999;
            if (tick && m_count != 0) sum = sum - 1;
            m_count = sum;
            m_since = m_since + 1;
        end
        sb_q.push_back(model_outputs());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_until_count(input int target, input int limit);
        int n = 0;
        while (m_count != target && n < limit) begin
            step(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        if (m_count != target) check("wait_count_timeout", m_count, target);
    endtask

    task automatic idle_until_presc(input int target);
        int n = 0;
        while ((m_since % T) != target && n < 2 * T) begin
            step(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        if ((m_since % T) != target) check("wait_presc_timeout", m_since % T, target);
    endtask

    // Monitor: one expectation per clock edge, sampled away from the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_bcd",   int'(bcd),   int'(e.bcd));
                check("sb_zero",  int'(zero),  int'(e.zero));
                check("sb_blank", int'(blank), int'(e.blank));
            end else if (running) begin
                check("sb_underflow", 0, 1);
            end
        end
    end

    initial begin
        // Reset, then idle: zero stays, blank follows the half-period pattern
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_bcd",   int'(bcd),   16'h0000);
        check("reset_zero",  int'(zero),  1);
        check("reset_blank", int'(blank), 0);
        idle(25);
        check("idle_stays_zero", int'(bcd), 16'h0000);

        // Basic add and countdown to zero
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("add_r", int'(bcd), 16'h0200);
        idle(9);
        check("first_dec", int'(bcd), 16'h0199);
        idle_until_count(0, 2100);
        check("countdown_zero", int'(zero), 1);
        idle(12);

        // Saturation and stacked pulses
        for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 0, 0, 1);
        check("saturate", int'(bcd), 16'h9999);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        check("stack_ul", int'(bcd), 16'h0190);

        // Switch overrides, then release
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 1);
        check("sw0_hold", int'(bcd), 16'h0015);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, 1);
        check("sw1_over_sw0", int'(bcd), 16'h0185);
        idle(9);
        check("release_no_dec_yet", int'(bcd), 16'h0185);
        idle(1);
        check("release_first_dec", int'(bcd), 16'h0184);

        // Tick and pulse in the same cycle at saturation
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 0, 0, 1);
        idle_until_presc(T - 2);
        step(0, 0, 0, 0, 0, 0, 1);
        check("pre_collision", int'(bcd), 16'h9999);
        step(0, 0, 0, 1, 0, 0, 0);
        check("collision", int'(bcd), 16'h9998);

        // Count of one expiring on a tick
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle_until_count(1, 200);
        idle_until_count(0, 2 * T);
        check("expire_zero", int'(zero), 1);
        idle(12);

        // Reset mid-run discards the coincident pulse
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle_until_count(437, 2000);
        step(1, 0, 0, 0, 1, 0, 0);
        check("reset_mid_run", int'(bcd), 16'h0000);
        idle(25);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 255) == 0,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0);
        end
        idle(5);

        #5;
        running = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
